modulo_fold_encoder: RTL and testbench
======================================

Name: modulo_fold_encoder

Overview:
- Forward model of the self-reset (modulo) ADC: folds a signed Q8.16 sample into [-LAMBDA, LAMBDA) and emits the 12-bit ADC code that the reconstruction pipeline consumes on its adc_in.
- Also reports the signed fold count k, where x = y + 2·LAMBDA·k, as ground truth for checking recovery.
- Sits upstream of the reconstruction top in loopback/self-test builds. Its adc_code output drives the reconstruction adc_in directly.

Parameters:
- WIDTH, 24, sample width (signed fixed point)
- FRACTIONAL_BITS, 16, fractional bits of x_in and y_out
- LAMBDA, 24'h00C000, fold threshold λ (0.75); 2λ is computed internally
- CODE_SCALE, 32'h0AAAAAAB, 4096/(2λ) in Q.32-relative scaling: code = ((y+λ)·CODE_SCALE) >> 32
- MAX_FOLDS, 127, iteration limit per sample

Ports:
- clk  in  1  clock; all registers update on falling edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- clk_en  in  1  sample-rate enable; state advances only when high
- valid_in  in  1  input sample valid
- x_in  in  WIDTH  signed Q8.16 input sample
- in_ready  out  1  block can accept a sample
- valid_out  out  1  one-enabled-cycle pulse: outputs valid
- adc_code  out  12  unsigned modulo ADC code, 0..4095
- y_out  out  WIDTH  signed folded value in [-λ, λ)
- fold_count  out  8  signed k
- overflow  out  1  asserted with valid_out when MAX_FOLDS was hit

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, valid_out=0, adc_code=0, y_out=0, fold_count=0, overflow=0; all internal registers cleared. Reset mid-fold discards the sample with no output.
- clk_en=0: every register holds, including valid_out, and no sample is accepted. valid_out is a pulse counted in enabled cycles.
- Accept: valid_in & in_ready & clk_en. Loads x into the accumulator, sets k=0, enters FOLD.
- IDLE: in_ready=1. valid_out drops to 0 on the first enabled edge after OUT.
- FOLD: in_ready=0. One step per enabled edge:
  - acc ≥ λ: acc -= 2λ, k += 1.
  - acc < -λ: acc += 2λ, k -= 1.
  - Otherwise: go to MUL.
  - If |k| reaches MAX_FOLDS while still out of range, set ovf, clamp acc to λ-1 (positive side) or -λ (negative side), and go to MUL.
- MUL: register p = (acc+λ) as an unsigned 18-bit value times CODE_SCALE (50-bit product). Go to OUT.
- OUT:
  - adc_code = min(p>>32, 4095).
  - y_out=acc, fold_count=k, overflow=ovf, valid_out=1.
  - in_ready=1, return to IDLE.
  - Back-to-back: a sample may be accepted on the same edge valid_out rises.
- Latency: valid_out rises |k|+3 enabled edges after the accept edge.
- valid_in while in_ready=0 is ignored; the source must hold the sample. There is no internal buffering.
- Boundaries:
  - x = λ folds to -λ (k=+1).
  - x = -λ stays (k=0).
  - Range is half-open, so exactly one representation exists.
- All arithmetic is signed WIDTH+1 bits, so add/sub of 2λ never wraps.
- Outputs hold their last values between pulses.

Test Plan:
- x=0x004000 (0.25) -> y=0x004000, k=0, adc_code=2730, valid_out 3 enabled edges after accept, overflow=0.
- x=0x020000 (2.0) -> y=0x008000, k=+1, adc_code=3413, latency 4. Then x=0xFE0000 (-2.0) -> y=0xFF8000, k=-1, adc_code=682.
- Boundaries:
  - x=0x00C000 -> y=0xFF4000, k=+1, adc_code=0.
  - x=0xFF4000 -> k=0, adc_code=0.
  - x=0xFF3FFF -> y=0x00BFFF, k=-1, adc_code=4095.
- x=0x7FFFFF -> k=85, y=0x007FFF, latency 88, overflow=0. valid_in pulses during FOLD are ignored and in_ready stays 0. Rerun with MAX_FOLDS=4 -> overflow=1, k=4, y=0x00BFFF.
- Toggle clk_en 1-of-3 during a k=+1 sample -> same outputs, latency 4 enabled edges, valid_out held high exactly one enabled cycle.
- Assert reset=0 mid-FOLD between edges -> all outputs zero immediately; after release, the next sample processes normally with no stale k.

Source files
------------

// File: rtl/modulo_fold_encoder_if.sv
// Sample-in / code-out bundle of the modulo fold encoder.
// The sample source drives "master"; the encoder sits on "slave".
interface modulo_fold_encoder_if #(
  parameter int WIDTH = 24
);
  logic             clk_en;
  logic             valid_in;
  logic [WIDTH-1:0] x_in;
  logic             in_ready;
  logic             valid_out;
  logic [11:0]      adc_code;
  logic [WIDTH-1:0] y_out;
  logic [7:0]       fold_count;
  logic             overflow;

  modport master (
    output clk_en, valid_in, x_in,
    input  in_ready, valid_out, adc_code, y_out, fold_count, overflow
  );

  modport slave (
    input  clk_en, valid_in, x_in,
    output in_ready, valid_out, adc_code, y_out, fold_count, overflow
  );
endinterface

// File: rtl/modulo_fold_encoder.sv
// Forward model of a self-reset (modulo) ADC: folds a signed sample into
// [-LAMBDA, LAMBDA), reports the fold count k and the 12-bit code. Falling-edge design.
module modulo_fold_encoder #(
  parameter int               WIDTH           = 24,
  parameter int               FRACTIONAL_BITS = 16,
  parameter logic [WIDTH-1:0] LAMBDA          = 24'h00C000,
  parameter logic [31:0]      CODE_SCALE      = 32'h0AAAAAAB,
  parameter int               MAX_FOLDS       = 127
) (
  input logic                  clk,
  input logic                  reset,
  modulo_fold_encoder_if.slave bus
);

  // One guard bit above WIDTH so that adding or removing 2*lambda never wraps.
  localparam logic signed [WIDTH:0] ONE_W     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic signed [WIDTH:0] LAM_W     = {1'b0, LAMBDA};
  localparam logic signed [WIDTH:0] NEG_LAM_W = -LAM_W;
  localparam logic signed [WIDTH:0] TWO_LAM_W = LAM_W + LAM_W;
  localparam logic signed [WIDTH:0] LAM_M1_W  = LAM_W - ONE_W;
  localparam logic signed [7:0]     K_MAX     = 8'(MAX_FOLDS);
  localparam logic signed [7:0]     K_MIN     = -K_MAX;

  if (FRACTIONAL_BITS >= WIDTH) begin : g_format_check
    $error("modulo_fold_encoder: FRACTIONAL_BITS must be below WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_MUL  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic signed [WIDTH:0]   acc_r;
  logic signed [WIDTH:0]   acc_nxt_s;
  logic signed [7:0]       k_r;
  logic signed [7:0]       k_nxt_s;
  logic                    ovf_r;
  logic                    ovf_nxt_s;
  logic [49:0]             prod_r;
  logic                    in_ready_r;
  logic                    valid_out_r;
  logic [11:0]             adc_code_r;
  logic [WIDTH-1:0]        y_out_r;
  logic [7:0]              fold_count_r;
  logic                    overflow_r;

  logic                    accept_s;
  logic signed [WIDTH:0]   x_ext_s;
  logic [17:0]             offset_s;
  logic [49:0]             prod_s;
  logic [11:0]             code_sat_s;

  assign accept_s = bus.clk_en & bus.valid_in & in_ready_r;
  assign x_ext_s  = {bus.x_in[WIDTH-1], bus.x_in};

  // (acc + lambda) lies in [0, 2*lambda) once folded, so 18 unsigned bits suffice.
  assign offset_s = 18'(acc_r + LAM_W);
  assign prod_s   = {32'd0, offset_s} * {18'd0, CODE_SCALE};

  // Saturate the scaled code to the 12-bit ADC range.
  always_comb begin
    code_sat_s = 12'd0;
    if (|prod_r[49:44]) begin
      code_sat_s = 12'hFFF;
    end else begin
      code_sat_s = prod_r[43:32];
    end
  end

  // Next-state and fold-step datapath.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    k_nxt_s     = k_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      ST_IDLE, ST_OUT: begin
        if (accept_s) begin
          state_nxt_s = ST_FOLD;
          acc_nxt_s   = x_ext_s;
          k_nxt_s     = 8'sd0;
          ovf_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FOLD: begin
        if (acc_r >= LAM_W) begin
          if (k_r == K_MAX) begin
            acc_nxt_s   = LAM_M1_W;
            ovf_nxt_s   = 1'b1;
            state_nxt_s = ST_MUL;
          end else begin
            acc_nxt_s = acc_r - TWO_LAM_W;
            k_nxt_s   = k_r + 8'sd1;
          end
        end else if (acc_r < NEG_LAM_W) begin
          if (k_r == K_MIN) begin
            acc_nxt_s   = NEG_LAM_W;
            ovf_nxt_s   = 1'b1;
            state_nxt_s = ST_MUL;
          end else begin
            acc_nxt_s = acc_r + TWO_LAM_W;
            k_nxt_s   = k_r - 8'sd1;
          end
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_MUL: begin
        state_nxt_s = ST_OUT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; clk_en low freezes the machine.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else if (bus.clk_en) begin
      state_r <= state_nxt_s;
    end
  end

  // Working registers and registered outputs.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      acc_r        <= '0;
      k_r          <= 8'sd0;
      ovf_r        <= 1'b0;
      prod_r       <= 50'd0;
      in_ready_r   <= 1'b1;
      valid_out_r  <= 1'b0;
      adc_code_r   <= 12'd0;
      y_out_r      <= '0;
      fold_count_r <= 8'd0;
      overflow_r   <= 1'b0;
    end else if (bus.clk_en) begin
      acc_r       <= acc_nxt_s;
      k_r         <= k_nxt_s;
      ovf_r       <= ovf_nxt_s;
      // Ready during OUT as well, so a new sample can enter as valid_out rises.
      in_ready_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_OUT);
      valid_out_r <= (state_r == ST_OUT);
      if (state_r == ST_MUL) begin
        prod_r <= prod_s;
      end
      if (state_r == ST_OUT) begin
        adc_code_r   <= code_sat_s;
        y_out_r      <= acc_r[WIDTH-1:0];
        fold_count_r <= k_r;
        overflow_r   <= ovf_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.adc_code   = adc_code_r;
  assign bus.y_out      = y_out_r;
  assign bus.fold_count = fold_count_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_modulo_fold_encoder.sv
// Bench for modulo_fold_encoder: a closed-form fold model compared every cycle,
// plus directed samples with hand-computed results.
module tb_modulo_fold_encoder;

  logic clk;
  logic reset;

  modulo_fold_encoder_if #(.WIDTH(24)) bus ();
  modulo_fold_encoder_if #(.WIDTH(24)) bus4 ();

  modulo_fold_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  modulo_fold_encoder #(.MAX_FOLDS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          en_edges = 0;
  int          acc_edge = 0;
  int          n_acc    = 0;
  int          m_rem    = 0;
  int          p_lat;
  bit          m_busy   = 1'b0;
  bit          take;
  logic        m_ready  = 1'b1;
  logic        m_valid  = 1'b0;
  logic [11:0] m_code   = 12'd0;
  logic [23:0] m_y      = 24'd0;
  logic [7:0]  m_k      = 8'd0;
  logic        m_ovf    = 1'b0;
  logic [11:0] p_code;
  logic [23:0] p_y;
  logic [7:0]  p_k;
  logic        p_ovf;
  bit          en_mode  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Closed form: k = floor((x + L) / 2L), y = x - 2L*k, saturated at +/-maxf folds.
  task automatic fold_model(input logic [23:0] x, input int maxf,
                            output logic [23:0] y, output logic [7:0] k,
                            output logic [11:0] code, output logic ovf, output int lat);
    longint xv, q, yv, c, num;
    longint lam, two_lam;
    lam     = 49152;
    two_lam = 98304;
    xv  = longint'($signed(x));
    num = xv + lam;
    q   = num / two_lam;
    if (num < 0 && (num % two_lam) != 0) q = q - 1;
    if (q > maxf) begin
      q = maxf; yv = lam - 1; ovf = 1'b1;
    end else if (q < -maxf) begin
      q = -maxf; yv = -lam; ovf = 1'b1;
    end else begin
      yv = xv - two_lam * q; ovf = 1'b0;
    end
    c = ((yv + lam) * 64'h0AAAAAAB) >>> 32;
    if (c > 4095) c = 4095;
    y    = 24'(yv);
    k    = 8'(q);
    code = 12'(c);
    lat  = int'((q < 0) ? -q : q) + 3;
  endtask

  // Reference model: pending result delivered |k|+3 enabled edges after accept.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_rem = 0; m_ready = 1'b1; m_valid = 1'b0;
      m_code = 12'd0; m_y = 24'd0; m_k = 8'd0; m_ovf = 1'b0;
    end else if (bus.clk_en) begin
      en_edges++;
      take    = bus.valid_in && m_ready;
      m_valid = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_valid = 1'b1;
          m_y = p_y; m_k = p_k; m_code = p_code; m_ovf = p_ovf;
        end
      end
      if (take) begin
        fold_model(bus.x_in, 127, p_y, p_k, p_code, p_ovf, p_lat);
        m_rem = p_lat; m_busy = 1'b1; acc_edge = en_edges; n_acc++;
      end
      m_ready = !m_busy || (m_rem == 1);
    end
  end

  // Compare DUT against the model on the opposite (rising) edge.
  always @(posedge clk) begin
    chk("cmp_in_ready",   bus.in_ready,   m_ready);
    chk("cmp_valid_out",  bus.valid_out,  m_valid);
    chk("cmp_adc_code",   bus.adc_code,   m_code);
    chk("cmp_y_out",      bus.y_out,      m_y);
    chk("cmp_fold_count", bus.fold_count, m_k);
    chk("cmp_overflow",   bus.overflow,   m_ovf);
  end

  // clk_en driver: always on, or 1-of-3 in gated mode.
  initial begin
    int ph;
    ph = 0;
    bus.clk_en = 1'b1;
    forever begin
      @(posedge clk);
      if (en_mode) begin
        ph = (ph == 2) ? 0 : ph + 1;
        bus.clk_en = (ph == 0);
      end else begin
        ph = 0;
        bus.clk_en = 1'b1;
      end
    end
  end

  task automatic wait_accept(input string nm, output int since);
    int  base;
    bit  got;
    base = n_acc;
    got  = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      if (n_acc != base) got = 1'b1;
    end
    chk({nm, "_accepted"}, got, 1'b1);
    since = acc_edge;
  endtask

  task automatic wait_out(input string nm, input int since, input bit poke);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      if (bus.valid_out && en_edges != since) begin
        got = 1'b1;
      end else if (poke && i >= 3 && i < 13) begin
        chk({nm, "_busy_ready"}, bus.in_ready, 1'b0);
        bus.valid_in = i[0];
        bus.x_in     = 24'h001000;
      end else if (poke) begin
        bus.valid_in = 1'b0;
      end
    end
    chk({nm, "_valid"}, got, 1'b1);
  endtask

  task automatic run(input logic [23:0] x, input logic [23:0] ey, input logic [7:0] ek,
                     input logic [11:0] ea, input logic eo, input int elat,
                     input bit poke, input string nm);
    int since;
    bus.valid_in = 1'b1;
    bus.x_in     = x;
    wait_accept(nm, since);
    bus.valid_in = 1'b0;
    wait_out(nm, since, poke);
    chk({nm, "_latency"}, en_edges - since, elat);
    chk({nm, "_y"},       bus.y_out,      ey);
    chk({nm, "_k"},       bus.fold_count, ek);
    chk({nm, "_code"},    bus.adc_code,   ea);
    chk({nm, "_ovf"},     bus.overflow,   eo);
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int since;
    int e0;
    int cnt;
    reset = 1'b1;
    bus.valid_in = 1'b0;  bus.x_in = 24'd0;
    bus4.clk_en = 1'b1;   bus4.valid_in = 1'b0; bus4.x_in = 24'd0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_in_ready",  bus.in_ready,   1'b1);
    chk("rst_valid_out", bus.valid_out,  1'b0);
    chk("rst_adc_code",  bus.adc_code,   12'd0);
    chk("rst_y_out",     bus.y_out,      24'd0);
    chk("rst_fold",      bus.fold_count, 8'd0);
    chk("rst_overflow",  bus.overflow,   1'b0);
    #2 reset = 1'b1;

    run(24'h004000, 24'h004000, 8'h00, 12'd2730, 1'b0, 3, 1'b0, "quarter");
    run(24'h020000, 24'h008000, 8'h01, 12'd3413, 1'b0, 4, 1'b0, "plus_two");
    run(24'hFE0000, 24'hFF8000, 8'hFF, 12'd682,  1'b0, 4, 1'b0, "minus_two");
    run(24'h00C000, 24'hFF4000, 8'h01, 12'd0,    1'b0, 4, 1'b0, "pos_lambda");
    run(24'hFF4000, 24'hFF4000, 8'h00, 12'd0,    1'b0, 3, 1'b0, "neg_lambda");
    run(24'hFF3FFF, 24'h00BFFF, 8'hFF, 12'd4095, 1'b0, 4, 1'b0, "below_neg");
    run(24'h7FFFFF, 24'h007FFF, 8'h55, 12'd3413, 1'b0, 88, 1'b1, "max_pos");

    // MAX_FOLDS=4 instance saturates after four folds
    @(posedge clk);
    bus4.valid_in = 1'b1;
    bus4.x_in     = 24'h7FFFFF;
    @(posedge clk);
    bus4.valid_in = 1'b0;
    cnt = 1;
    while (!bus4.valid_out && cnt < 50) begin
      @(posedge clk);
      cnt++;
    end
    chk("max4_valid",   bus4.valid_out,  1'b1);
    chk("max4_latency", cnt - 1,         7);
    chk("max4_k",       bus4.fold_count, 8'h04);
    chk("max4_y",       bus4.y_out,      24'h00BFFF);
    chk("max4_ovf",     bus4.overflow,   1'b1);
    chk("max4_code",    bus4.adc_code,   12'd4095);

    // clk_en gated 1-of-3
    en_mode = 1'b1;
    run(24'h020000, 24'h008000, 8'h01, 12'd3413, 1'b0, 4, 1'b0, "gated");
    e0 = en_edges;
    for (int i = 0; i < 20 && en_edges == e0; i++) @(posedge clk);
    chk("gated_pulse_drop", bus.valid_out, 1'b0);
    en_mode = 1'b0;
    repeat (3) @(posedge clk);

    // back-to-back: second sample enters on the edge the first result appears
    bus.valid_in = 1'b1;
    bus.x_in     = 24'h004000;
    wait_accept("b2b_a", since);
    bus.x_in     = 24'h020000;
    wait_out("b2b_a", since, 1'b0);
    chk("b2b_a_y",       bus.y_out,         24'h004000);
    chk("b2b_a_latency", en_edges - since,  3);
    chk("b2b_b_taken",   bus.in_ready,      1'b0);
    bus.valid_in = 1'b0;
    since = acc_edge;
    wait_out("b2b_b", since, 1'b0);
    chk("b2b_b_y",       bus.y_out,         24'h008000);
    chk("b2b_b_k",       bus.fold_count,    8'h01);
    chk("b2b_b_latency", en_edges - since,  4);

    // asynchronous reset in the middle of a long fold
    bus.valid_in = 1'b1;
    bus.x_in     = 24'h7FFFFF;
    wait_accept("midrst", since);
    bus.valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready,   1'b1);
    chk("midrst_valid",    bus.valid_out,  1'b0);
    chk("midrst_code",     bus.adc_code,   12'd0);
    chk("midrst_y",        bus.y_out,      24'd0);
    chk("midrst_k",        bus.fold_count, 8'd0);
    chk("midrst_ovf",      bus.overflow,   1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    run(24'h020000, 24'h008000, 8'h01, 12'd3413, 1'b0, 4, 1'b0, "after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
